// File: rtl/raspi_bus_if.sv
// Raspi bus interface: pin synchronisers, glitch filters,
// direction FSM with hi-Z turnaround and a sticky conflict flag.
module raspi_bus_if #(
  parameter int DW     = 12,
  parameter int NCTL   = 3,
  parameter int FILT   = 2,
  parameter int TURN   = 2,
  parameter int INVERT = 1
) (
  input  logic            uclk,
  input  logic            _RESET,
  input  logic            PCLK,
  input  logic            PDENA,
  input  logic            PQENA,
  input  logic [NCTL-1:0] PCTL,
  inout  wire  [DW:0]     PBUS,
  input  logic [DW:0]     MD,
  output logic            CLKEN,
  output logic            CLKLVL,
  output logic [NCTL-1:0] CTL,
  output logic [DW:0]     MQ,
  output logic            DRIVING,
  output logic            BUSERR
);

  localparam int NI = NCTL + 3;
  localparam logic [NI-1:0] INV_M =
    (INVERT != 0) ? {{NCTL{1'b1}}, 2'b00, 1'b1} : '0;
  localparam logic [DW:0] BUS_INV =
    (INVERT != 0) ? {(DW+1){1'b1}} : '0;
  localparam logic [3:0] FLIM = 4'(FILT - 1);
  localparam logic [3:0] TLD  = 4'(TURN);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRIVE      = 2'd1,
    RECV       = 2'd2,
    TURNAROUND = 2'd3
  } st_t;

  // filtered input bit order: {ctl, qena, dena, clk}
  logic [NI-1:0] raw;
  logic [NI-1:0] s1_q, s2_q;
  logic [NI-1:0] flt_q, flt_d;
  logic [3:0]    cnt_q [NI];
  logic [3:0]    cnt_d [NI];
  logic          lvl_q;

  st_t           st_q, st_d;
  logic [3:0]    tcnt_q, tcnt_d;
  logic          err_q, err_d;
  logic          drv_q;
  logic [DW:0]   oreg_q;
  logic [DW:0]   b1_q, b2_q;

  logic dena, qena, conf;

  assign raw  = {PCTL, PQENA, PDENA, PCLK};
  assign dena = flt_q[1];
  assign qena = flt_q[2];
  assign conf = dena & qena;

  // per-input filter: flip after FILT consecutive differing samples
  always_comb begin
    flt_d = flt_q;
    for (int i = 0; i < NI; i++) begin
      cnt_d[i] = 4'd0;
      if (s2_q[i] != flt_q[i]) begin
        if (cnt_q[i] >= FLIM) flt_d[i] = ~flt_q[i];
        else cnt_d[i] = cnt_q[i] + 4'd1;
      end
    end
  end

  // synchronisers, filter state and clock edge history
  always_ff @(posedge uclk) begin
    if (!_RESET) begin
      s1_q  <= '0;
      s2_q  <= '0;
      flt_q <= '0;
      lvl_q <= 1'b0;
      for (int i = 0; i < NI; i++) cnt_q[i] <= 4'd0;
    end else begin
      s1_q  <= raw ^ INV_M;
      s2_q  <= s1_q;
      flt_q <= flt_d;
      lvl_q <= flt_q[0];
      for (int i = 0; i < NI; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // direction FSM next state, turnaround count, conflict flag
  always_comb begin
    st_d   = st_q;
    tcnt_d = tcnt_q;
    err_d  = err_q | conf;
    unique case (st_q)
      IDLE: begin
        if (!conf) begin
          if (dena)      st_d = DRIVE;
          else if (qena) st_d = RECV;
        end
      end
      DRIVE: begin
        if (conf || !dena) begin
          st_d   = TURNAROUND;
          tcnt_d = TLD;
        end
      end
      RECV: begin
        if (conf || !qena) begin
          st_d   = TURNAROUND;
          tcnt_d = TLD;
        end
      end
      TURNAROUND: begin
        tcnt_d = (tcnt_q != 4'd0) ? tcnt_q - 4'd1 : 4'd0;
        if (tcnt_q <= 4'd1) st_d = IDLE;
      end
      default: st_d = IDLE;
    endcase
  end

  // FSM, drive enable and bus data registers
  always_ff @(posedge uclk) begin
    if (!_RESET) begin
      st_q   <= IDLE;
      tcnt_q <= 4'd0;
      err_q  <= 1'b0;
      drv_q  <= 1'b0;
      oreg_q <= '0;
      b1_q   <= '0;
      b2_q   <= '0;
    end else begin
      st_q   <= st_d;
      tcnt_q <= tcnt_d;
      err_q  <= err_d;
      drv_q  <= (st_d == DRIVE);
      oreg_q <= MD ^ BUS_INV;
      b1_q   <= PBUS ^ BUS_INV;
      b2_q   <= b1_q;
    end
  end

  assign PBUS    = drv_q ? oreg_q : {(DW+1){1'bz}};
  assign DRIVING = drv_q;
  assign BUSERR  = err_q;
  assign CLKLVL  = flt_q[0];
  assign CLKEN   = flt_q[0] & ~lvl_q;
  assign CTL     = flt_q[NI-1:3];
  assign MQ      = (st_q == RECV) ? b2_q : '0;

endmodule

// File: tb/tb_raspi_bus_if.sv
// Directed bench for raspi_bus_if with default parameters.
// Hi-Z is observed by the bench driving a pattern onto PBUS.
module tb_raspi_bus_if;

  logic        uclk = 1'b0;
  logic        rst_n;
  logic        pclk, pdena, pqena;
  logic [2:0]  pctl;
  logic [12:0] md;
  wire  [12:0] pbus;
  logic        tb_en;
  logic [12:0] tb_val;
  logic        clken, clklvl, driving, buserr;
  logic [2:0]  ctl;
  logic [12:0] mq;

  int total = 0;
  int bad   = 0;

  assign pbus = tb_en ? tb_val : 13'bz;

  raspi_bus_if dut (
    .uclk    (uclk),
    ._RESET  (rst_n),
    .PCLK    (pclk),
    .PDENA   (pdena),
    .PQENA   (pqena),
    .PCTL    (pctl),
    .PBUS    (pbus),
    .MD      (md),
    .CLKEN   (clken),
    .CLKLVL  (clklvl),
    .CTL     (ctl),
    .MQ      (mq),
    .DRIVING (driving),
    .BUSERR  (buserr)
  );

  always #5 uclk = ~uclk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge uclk);
      #1;
    end
  endtask

  task automatic test_reset();
    pclk = 1; pdena = 0; pqena = 0; pctl = 3'b111;
    md = 13'h0; tb_en = 1; tb_val = 13'h0AAA; rst_n = 0;
    tick(3);
    total++;
    if ({clken, clklvl, ctl, driving, buserr} !== 7'd0) begin
      bad++;
      $display("FAIL rst_outs got=%b want=0",
               {clken, clklvl, ctl, driving, buserr});
    end
    total++;
    if (mq !== 13'h0) begin
      bad++; $display("FAIL rst_mq got=%h want=0", mq);
    end
    total++;
    if (pbus !== 13'h0AAA) begin
      bad++; $display("FAIL rst_hiz got=%h want=0aaa", pbus);
    end
    rst_n = 1;
    tick(6);
    total++;
    if ({clken, clklvl, ctl, driving, buserr} !== 7'd0) begin
      bad++;
      $display("FAIL idle_outs got=%b want=0",
               {clken, clklvl, ctl, driving, buserr});
    end
  endtask

  task automatic test_clken();
    logic extra;
    pclk = 0;
    tick(3);
    total++;
    if (clklvl !== 1'b0) begin
      bad++; $display("FAIL clk_e3 got=%b want=0", clklvl);
    end
    tick(1);
    total++;
    if ({clklvl, clken} !== 2'b11) begin
      bad++; $display("FAIL clk_e4 got=%b want=11", {clklvl, clken});
    end
    tick(1);
    total++;
    if ({clklvl, clken} !== 2'b10) begin
      bad++; $display("FAIL clk_e5 got=%b want=10", {clklvl, clken});
    end
    extra = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      extra |= clken;
    end
    total++;
    if (extra !== 1'b0) begin
      bad++; $display("FAIL clk_held got=%b want=0", extra);
    end
    pclk = 1;
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      extra |= clken;
    end
    total++;
    if ({extra, clklvl} !== 2'b00) begin
      bad++; $display("FAIL clk_fall got=%b want=00", {extra, clklvl});
    end
  endtask

  task automatic test_glitch();
    logic seen;
    pctl[1] = 0;
    tick(1);
    pctl[1] = 1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      seen |= ctl[1];
    end
    total++;
    if (seen !== 1'b0) begin
      bad++; $display("FAIL glitch got=%b want=0", seen);
    end
    pctl[1] = 0;
    tick(3);
    total++;
    if (ctl[1] !== 1'b0) begin
      bad++; $display("FAIL ctl_e3 got=%b want=0", ctl[1]);
    end
    tick(1);
    total++;
    if (ctl !== 3'b010) begin
      bad++; $display("FAIL ctl_e4 got=%b want=010", ctl);
    end
    pctl = 3'b111;
    tick(6);
    total++;
    if (ctl !== 3'b000) begin
      bad++; $display("FAIL ctl_rel got=%b want=000", ctl);
    end
  endtask

  task automatic test_drive();
    md = 13'h1A5C; tb_en = 0; pdena = 1;
    tick(4);
    total++;
    if (driving !== 1'b0) begin
      bad++; $display("FAIL drv_e4 got=%b want=0", driving);
    end
    tick(1);
    total++;
    if (driving !== 1'b1 || pbus !== 13'h05A3) begin
      bad++;
      $display("FAIL drv_on got=%b/%h want=1/05a3", driving, pbus);
    end
    md = 13'h0000;
    #1;
    total++;
    if (pbus !== 13'h05A3) begin
      bad++; $display("FAIL drv_lag got=%h want=05a3", pbus);
    end
    tick(1);
    total++;
    if (pbus !== 13'h1FFF) begin
      bad++; $display("FAIL drv_upd got=%h want=1fff", pbus);
    end
    pdena = 0;
    tick(4);
    total++;
    if (driving !== 1'b1) begin
      bad++; $display("FAIL drv_hold got=%b want=1", driving);
    end
    tick(1);
    tb_en = 1; tb_val = 13'h0AAA;
    #1;
    total++;
    if (driving !== 1'b0 || pbus !== 13'h0AAA ||
        dut.st_q !== 2'd3) begin
      bad++;
      $display("FAIL drv_ta got=%b/%h/%0d want=0/0aaa/3",
               driving, pbus, dut.st_q);
    end
    tick(1);
    total++;
    if (dut.st_q !== 2'd3 || pbus !== 13'h0AAA) begin
      bad++;
      $display("FAIL drv_ta2 got=%0d/%h want=3/0aaa", dut.st_q, pbus);
    end
    tick(1);
    total++;
    if (dut.st_q !== 2'd0) begin
      bad++; $display("FAIL drv_idle got=%0d want=0", dut.st_q);
    end
  endtask

  task automatic test_recv();
    tb_en = 1; tb_val = 13'h1FFF; pqena = 1;
    tick(5);
    total++;
    if (dut.st_q !== 2'd2 || mq !== 13'h0) begin
      bad++;
      $display("FAIL rcv_in got=%0d/%h want=2/0000", dut.st_q, mq);
    end
    tb_val = 13'h1FFE;
    tick(1);
    total++;
    if (mq !== 13'h0) begin
      bad++; $display("FAIL rcv_e1 got=%h want=0000", mq);
    end
    tick(1);
    total++;
    if (mq !== 13'h0001) begin
      bad++; $display("FAIL rcv_e2 got=%h want=0001", mq);
    end
    pqena = 0;
    tick(4);
    total++;
    if (mq !== 13'h0001) begin
      bad++; $display("FAIL rcv_hold got=%h want=0001", mq);
    end
    tick(1);
    total++;
    if (mq !== 13'h0 || dut.st_q !== 2'd3) begin
      bad++;
      $display("FAIL rcv_ta got=%h/%0d want=0000/3", mq, dut.st_q);
    end
    tick(2);
    total++;
    if (dut.st_q !== 2'd0 || driving !== 1'b0) begin
      bad++;
      $display("FAIL rcv_idle got=%0d/%b want=0/0", dut.st_q, driving);
    end
  endtask

  task automatic test_conflict();
    logic drove;
    tb_en = 1; tb_val = 13'h1FFF; pqena = 1;
    tick(5);
    drove = 0;
    pdena = 1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      drove |= driving | (pbus !== 13'h1FFF);
    end
    total++;
    if (dut.st_q !== 2'd3 || buserr !== 1'b1) begin
      bad++;
      $display("FAIL cnf_ta got=%0d/%b want=3/1", dut.st_q, buserr);
    end
    pdena = 0; pqena = 0;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      drove |= driving | (pbus !== 13'h1FFF);
    end
    total++;
    if (drove !== 1'b0) begin
      bad++; $display("FAIL cnf_drive got=%b want=0", drove);
    end
    total++;
    if (buserr !== 1'b1 || dut.st_q !== 2'd0) begin
      bad++;
      $display("FAIL cnf_sticky got=%b/%0d want=1/0", buserr, dut.st_q);
    end
    rst_n = 0;
    tick(1);
    rst_n = 1;
    total++;
    if (buserr !== 1'b0) begin
      bad++; $display("FAIL cnf_clr got=%b want=0", buserr);
    end
  endtask

  task automatic test_back_to_back();
    tb_en = 0; md = 13'h0F0F; pdena = 1;
    tick(5);
    total++;
    if (driving !== 1'b1) begin
      bad++; $display("FAIL swp_drv got=%b want=1", driving);
    end
    pdena = 0; pqena = 1;
    tick(4);
    total++;
    if (dut.st_q !== 2'd1) begin
      bad++; $display("FAIL swp_e4 got=%0d want=1", dut.st_q);
    end
    tick(1);
    total++;
    if (driving !== 1'b0 || dut.st_q !== 2'd3) begin
      bad++;
      $display("FAIL swp_e5 got=%b/%0d want=0/3", driving, dut.st_q);
    end
    tick(1);
    total++;
    if (dut.st_q !== 2'd3) begin
      bad++; $display("FAIL swp_e6 got=%0d want=3", dut.st_q);
    end
    tick(1);
    total++;
    if (dut.st_q !== 2'd0) begin
      bad++; $display("FAIL swp_e7 got=%0d want=0", dut.st_q);
    end
    tick(1);
    total++;
    if (dut.st_q !== 2'd2 || driving !== 1'b0) begin
      bad++;
      $display("FAIL swp_e8 got=%0d/%b want=2/0", dut.st_q, driving);
    end
    pqena = 0;
    tick(8);
  endtask

  task automatic test_reset_drive();
    tb_en = 0; md = 13'h1A5C; pdena = 1; pctl[0] = 0;
    tick(5);
    total++;
    if (driving !== 1'b1 || ctl[0] !== 1'b1) begin
      bad++;
      $display("FAIL rd_pre got=%b/%b want=1/1", driving, ctl[0]);
    end
    rst_n = 0;
    tick(1);
    rst_n = 1;
    tb_en = 1; tb_val = 13'h0AAA;
    #1;
    total++;
    if (driving !== 1'b0 || mq !== 13'h0 || dut.st_q !== 2'd0 ||
        pbus !== 13'h0AAA || ctl !== 3'b000) begin
      bad++;
      $display("FAIL rd_rst got=%b/%h/%0d/%h/%b want=0/0000/0/0aaa/000",
               driving, mq, dut.st_q, pbus, ctl);
    end
    #3;
    tb_en = 0;
    tick(3);
    total++;
    if (ctl[0] !== 1'b0 || driving !== 1'b0) begin
      bad++;
      $display("FAIL rd_e3 got=%b/%b want=0/0", ctl[0], driving);
    end
    tick(1);
    total++;
    if (ctl[0] !== 1'b1 || driving !== 1'b0) begin
      bad++;
      $display("FAIL rd_e4 got=%b/%b want=1/0", ctl[0], driving);
    end
    tick(1);
    total++;
    if (driving !== 1'b1 || pbus !== 13'h05A3) begin
      bad++;
      $display("FAIL rd_e5 got=%b/%h want=1/05a3", driving, pbus);
    end
  endtask

  initial begin
    test_reset();
    test_clken();
    test_glitch();
    test_drive();
    test_recv();
    test_conflict();
    test_back_to_back();
    test_reset_drive();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
